// File: rtl/can_frame_rx.sv
// Extended-format CAN frame receiver: destuffs, checks CRC-15 and form, drives ACK, presents good frames.
// Latency: results and valid are registered on the edge that samples EOF bit 7; errors flag on the detecting edge.
// Backpressure: none; the bus sets the pace and a result is held only until the next good frame overwrites it.
module can_frame_rx #(
    parameter int IDLE_BITS = 11,
    parameter int IFS_BITS  = 3
) (
    input  logic        clk_can_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        tx_ack_o,
    output logic        rx_busy_o,
    output logic        rx_valid_o,
    output logic [28:0] rx_id_o,
    output logic        rx_rtr_o,
    output logic [3:0]  rx_dlc_o,
    output logic [63:0] rx_data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    typedef enum logic [3:0] {
        S_WAIT_IDLE,
        S_WAIT_SOF,
        S_ARB,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_ACK_DEL,
        S_EOF,
        S_IFS
    } state_t;

    localparam logic [7:0]  IDLE_LIM = 8'(IDLE_BITS);
    localparam logic [7:0]  IFS_LIM  = 8'(IFS_BITS);
    localparam logic [14:0] CRC_POLY = 15'h4599;

    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_FORM  = 2'b10;
    localparam logic [1:0] ERR_CRC   = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;          // idle/IFS run length, or bit index within the current field
    logic [2:0]  run_q, run_d;          // raw equal-bit run length for destuffing
    logic        last_q, last_d;        // level of the previous raw bit
    logic [14:0] crc_q, crc_d;          // computed CRC
    logic [14:0] crc_rx_q, crc_rx_d;    // received CRC field
    logic [28:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;

    logic        tx_ack_q, tx_ack_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [28:0] rx_id_q, rx_id_d;
    logic        rx_rtr_q, rx_rtr_d;
    logic [3:0]  rx_dlc_q, rx_dlc_d;
    logic [63:0] rx_data_q, rx_data_d;

    logic        err_hit;
    logic [1:0]  err_kind;

    logic [14:0] crc_step;
    logic        destuff_zone;
    logic        stuff_slot;
    logic [3:0]  dlc_full;
    logic [7:0]  data_last;

    assign crc_step     = {crc_q[13:0], 1'b0} ^ ((rx_i ^ crc_q[14]) ? CRC_POLY : 15'h0000);
    // CRC_DEL belongs to the destuff window only when a trailing stuff bit is due after the CRC
    assign destuff_zone = (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL});
    assign stuff_slot   = destuff_zone && (run_q == 3'd5);
    assign dlc_full     = {dlc_q[2:0], rx_i};
    assign data_last    = dlc_q[3] ? 8'd63 : ({2'b00, dlc_q[2:0], 3'b000} - 8'd1);

    // Next-state and next-output logic for the whole receive sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        last_d     = last_q;
        crc_d      = crc_q;
        crc_rx_d   = crc_rx_q;
        id_d       = id_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        data_d     = data_q;
        tx_ack_d   = 1'b1;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        rx_id_d    = rx_id_q;
        rx_rtr_d   = rx_rtr_q;
        rx_dlc_d   = rx_dlc_q;
        rx_data_d  = rx_data_q;
        err_hit    = 1'b0;
        err_kind   = ERR_FORM;

        if (stuff_slot) begin
            // Stuff bit: must be the complement of the run, then it is dropped
            if (rx_i == last_q) begin
                err_hit  = 1'b1;
                err_kind = ERR_STUFF;
            end else begin
                run_d  = 3'd1;
                last_d = rx_i;
            end
        end else begin
            if (destuff_zone) begin
                run_d  = (rx_i == last_q) ? run_q + 3'd1 : 3'd1;
                last_d = rx_i;
            end

            case (state_q)
                S_WAIT_IDLE: begin
                    if (!rx_i) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q + 8'd1 == IDLE_LIM) begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT_SOF;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                S_WAIT_SOF: begin
                    if (!rx_i) begin
                        // SOF is a dominant 0 fed into a cleared CRC, which leaves it at zero
                        state_d  = S_ARB;
                        busy_d   = 1'b1;
                        cnt_d    = 8'd0;
                        run_d    = 3'd1;
                        last_d   = 1'b0;
                        crc_d    = 15'h0000;
                        crc_rx_d = 15'h0000;
                        id_d     = 29'd0;
                        rtr_d    = 1'b0;
                        dlc_d    = 4'd0;
                        data_d   = 64'd0;
                    end
                end

                S_ARB: begin
                    crc_d = crc_step;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd11) begin
                        if (!rx_i) begin
                            err_hit  = 1'b1;
                            err_kind = ERR_FORM;
                        end
                    end else if (cnt_q == 8'd12) begin
                        // Standard-format frame: not ours, drop it quietly
                        if (!rx_i) begin
                            state_d = S_WAIT_IDLE;
                            busy_d  = 1'b0;
                            cnt_d   = 8'd0;
                        end
                    end else if (cnt_q == 8'd31) begin
                        rtr_d   = rx_i;
                        state_d = S_CTRL;
                        cnt_d   = 8'd0;
                    end else begin
                        id_d = {id_q[27:0], rx_i};
                    end
                end

                S_CTRL: begin
                    crc_d = crc_step;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q >= 8'd2) begin
                        dlc_d = dlc_full;
                    end
                    if (cnt_q == 8'd5) begin
                        cnt_d   = 8'd0;
                        state_d = (rtr_q || dlc_full == 4'd0) ? S_CRC : S_DATA;
                    end
                end

                S_DATA: begin
                    crc_d                = crc_step;
                    data_d[~cnt_q[5:0]] = rx_i;
                    cnt_d                = cnt_q + 8'd1;
                    if (cnt_q == data_last) begin
                        cnt_d   = 8'd0;
                        state_d = S_CRC;
                    end
                end

                S_CRC: begin
                    crc_rx_d = {crc_rx_q[13:0], rx_i};
                    cnt_d    = cnt_q + 8'd1;
                    if (cnt_q == 8'd14) begin
                        cnt_d   = 8'd0;
                        state_d = S_CRC_DEL;
                    end
                end

                S_CRC_DEL: begin
                    if (crc_rx_q != crc_q) begin
                        err_hit  = 1'b1;
                        err_kind = ERR_CRC;
                    end else if (!rx_i) begin
                        err_hit  = 1'b1;
                        err_kind = ERR_FORM;
                    end else begin
                        tx_ack_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end

                S_ACK: begin
                    state_d = S_ACK_DEL;
                end

                S_ACK_DEL: begin
                    if (!rx_i) begin
                        err_hit  = 1'b1;
                        err_kind = ERR_FORM;
                    end else begin
                        state_d = S_EOF;
                        cnt_d   = 8'd0;
                    end
                end

                S_EOF: begin
                    if (!rx_i) begin
                        err_hit  = 1'b1;
                        err_kind = ERR_FORM;
                    end else if (cnt_q == 8'd6) begin
                        rx_id_d   = id_q;
                        rx_rtr_d  = rtr_q;
                        rx_dlc_d  = dlc_q;
                        rx_data_d = data_q;
                        valid_d   = 1'b1;
                        busy_d    = 1'b0;
                        cnt_d     = 8'd0;
                        state_d   = S_IFS;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                S_IFS: begin
                    if (!rx_i) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q + 8'd1 == IFS_LIM) begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT_SOF;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_d = S_WAIT_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // Any error abandons the frame and leaves the results untouched
        if (err_hit) begin
            state_d    = S_WAIT_IDLE;
            cnt_d      = 8'd0;
            busy_d     = 1'b0;
            tx_ack_d   = 1'b1;
            err_d      = 1'b1;
            err_code_d = err_kind;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_can_i) begin
        if (rst_i) begin
            state_q    <= S_WAIT_IDLE;
            cnt_q      <= 8'd0;
            run_q      <= 3'd0;
            last_q     <= 1'b1;
            crc_q      <= 15'h0000;
            crc_rx_q   <= 15'h0000;
            id_q       <= 29'd0;
            rtr_q      <= 1'b0;
            dlc_q      <= 4'd0;
            data_q     <= 64'd0;
            tx_ack_q   <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            rx_id_q    <= 29'd0;
            rx_rtr_q   <= 1'b0;
            rx_dlc_q   <= 4'd0;
            rx_data_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            last_q     <= last_d;
            crc_q      <= crc_d;
            crc_rx_q   <= crc_rx_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rx_id_q    <= rx_id_d;
            rx_rtr_q   <= rx_rtr_d;
            rx_dlc_q   <= rx_dlc_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign tx_ack_o   = tx_ack_q;
    assign rx_busy_o  = busy_q;
    assign rx_valid_o = valid_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign rx_id_o    = rx_id_q;
    assign rx_rtr_o   = rx_rtr_q;
    assign rx_dlc_o   = rx_dlc_q;
    assign rx_data_o  = rx_data_q;

endmodule
